// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces pixel/line counters, sync, blanking and frame strobes, advancing
// on a pixel clock-enable. Every output is registered and describes the
// hcount/vcount it is presented with; there is no extra latency stage.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned FRM_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             line_start,
  output logic             frame_start,
  output logic [FRM_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ON    = 1'(HS_POL);
  localparam logic             VS_ON    = 1'(VS_POL);

  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end
  if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_bad_width
    $error("vga_timing_gen: CNT_W too small for the raster totals");
  end

  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             hblnk_nxt;
  logic             vblnk_nxt;
  logic             hsync_nxt;
  logic             vsync_nxt;

  // Next raster position and the flags that will accompany it.
  // Wrap tests use >= so an out-of-range counter falls back to 0.
  always_comb begin
    h_wrap    = (hcount >= H_LAST);
    v_wrap    = (vcount >= V_LAST);
    h_nxt     = h_wrap ? '0 : hcount + CNT_W'(1);
    v_nxt     = vcount;
    if (h_wrap) begin
      v_nxt   = v_wrap ? '0 : vcount + CNT_W'(1);
    end
    hblnk_nxt = (h_nxt >= H_ACT_C);
    vblnk_nxt = (v_nxt >= V_ACT_C);
    hsync_nxt = (h_nxt >= HS_BEG && h_nxt < HS_END) ? HS_ON : ~HS_ON;
    vsync_nxt = (v_nxt >= VS_BEG && v_nxt < VS_END) ? VS_ON : ~VS_ON;
  end

  // Raster state: advance on pix_ce, strobes last a single clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (pix_ce) begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hblnk       <= hblnk_nxt;
      vblnk       <= vblnk_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
      if (h_wrap && v_wrap) begin
        frame_cnt <= frame_cnt + FRM_W'(1);
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Produces pixel/line counters, sync, blanking and frame strobes for any resolution/porch set.
- Advances on a pixel clock-enable, so one system clock can serve several pixel rates.
- Sits at the head of the video pipeline, feeding the draw/overlay stages of the game.
- Defaults give 1024x768 @ 60 Hz with a 65 MHz pixel rate.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, horizontal sync width (pixels)
H_BP, 160, horizontal back porch (pixels); H_TOTAL = sum of the four = 1344
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines); V_TOTAL = 806
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
CNT_W, 11, counter width; must satisfy 2^CNT_W >= max(H_TOTAL, V_TOTAL)
FRM_W, 8, frame counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
pix_ce  in  1  pixel clock-enable; counters advance only when high
hcount  out  CNT_W  current pixel column, 0..H_TOTAL-1
vcount  out  CNT_W  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync at HS_POL level while active
vsync  out  1  vertical sync at VS_POL level while active
hblnk  out  1  high when hcount >= H_ACTIVE
vblnk  out  1  high when vcount >= V_ACTIVE
line_start  out  1  one-clk pulse when hcount wraps to 0
frame_start  out  1  one-clk pulse when hcount and vcount both wrap to 0
frame_cnt  out  FRM_W  frames completed, wraps modulo 2^FRM_W

Behaviour:
- Reset values (async, immediate): hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0, frame_cnt=0.
- First rising clk with rst low and pix_ce high moves the raster to (1,0).
- All outputs are registered and mutually aligned. Flags are computed from the next counter values and loaded in the same edge as the counters, so flags always describe the hcount/vcount presented with them. There is no extra latency stage.
- On a clk edge with pix_ce=1:
  - hcount <= (hcount == H_TOTAL-1) ? 0 : hcount+1.
  - When hcount wraps, vcount <= (vcount == V_TOTAL-1) ? 0 : vcount+1.
- On a clk edge with pix_ce=0: every register holds, and line_start and frame_start are forced to 0. Strobes last one clk, not one pixel.
- hsync active for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
- vsync active for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC. vsync changes only at the edge where hcount becomes 0.
- line_start=1 on the clk where hcount becomes 0 (including the frame wrap).
- frame_start=1 on the clk where (hcount,vcount) becomes (0,0).
- frame_cnt increments on that same edge and wraps from 2^FRM_W-1 to 0 with no flag.
- Reset mid-frame returns to (0,0) immediately. No frame_start pulse is issued for the reset itself. frame_cnt clears.
- pix_ce permanently high: full-rate operation, one pixel per clk.
- Counter arithmetic is unsigned CNT_W-bit. There is no illegal state: the comparisons use >= H_TOTAL-1 / >= V_TOTAL-1, so a counter that is out of range wraps to 0.
- Elaboration check fails if any porch/sync parameter is 0 or a total exceeds 2^CNT_W.

Test Plan:
- Reset then pix_ce=1 for 1344*806 clks -> exactly one frame_start at the (0,0) wrap; 806 line_start pulses; frame_cnt=1; hcount max 1343, vcount max 805.
- Sample line 0 -> hblnk rises at hcount=1024. hsync low for hcount 1048..1183 and high at hcount 1184. hblnk falls at hcount=0.
- Sample frame -> vblnk high for vcount 768..805. vsync low for vcount 771..776, with both edges coincident with hcount=0.
- pix_ce toggled 1,0,1,0 (50% duty) -> hcount advances every 2nd clk; frame_start width 1 clk; frame period 2*1344*806 clks.
- Assert rst at (hcount=500, vcount=400) for 3 clks -> outputs at reset values within the same cycle; restart from (0,0) with frame_cnt=0 and no spurious frame_start.
- Override params H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33, FRM_W=2 -> totals 800x525; frame_cnt reads 0,1,2,3,0 over 4 frames.
